// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer for the Mini SRC datapath
// Fetch T0..T2, opcode-class execute T3..T7, with halt, stop and reset sequencing.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        BAout,
  output logic        Cout,
  output logic        R15in,
  output logic        PORTin,
  output logic        PORTout,
  output logic        CONin,
  output logic        run,
  output logic [2:0]  step
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_UN, C_MD, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_e;

  localparam logic [27:0] M_PCOUT   = 28'd1 << 0;
  localparam logic [27:0] M_INCPC   = 28'd1 << 1;
  localparam logic [27:0] M_PCIN    = 28'd1 << 2;
  localparam logic [27:0] M_MARIN   = 28'd1 << 3;
  localparam logic [27:0] M_MDRIN   = 28'd1 << 4;
  localparam logic [27:0] M_MDROUT  = 28'd1 << 5;
  localparam logic [27:0] M_READ    = 28'd1 << 6;
  localparam logic [27:0] M_WRITE   = 28'd1 << 7;
  localparam logic [27:0] M_IRIN    = 28'd1 << 8;
  localparam logic [27:0] M_RYIN    = 28'd1 << 9;
  localparam logic [27:0] M_RZIN    = 28'd1 << 10;
  localparam logic [27:0] M_RZLOOUT = 28'd1 << 11;
  localparam logic [27:0] M_RZHIOUT = 28'd1 << 12;
  localparam logic [27:0] M_HIIN    = 28'd1 << 13;
  localparam logic [27:0] M_LOIN    = 28'd1 << 14;
  localparam logic [27:0] M_HIOUT   = 28'd1 << 15;
  localparam logic [27:0] M_LOOUT   = 28'd1 << 16;
  localparam logic [27:0] M_GRA     = 28'd1 << 17;
  localparam logic [27:0] M_GRB     = 28'd1 << 18;
  localparam logic [27:0] M_GRC     = 28'd1 << 19;
  localparam logic [27:0] M_RIN     = 28'd1 << 20;
  localparam logic [27:0] M_ROUT    = 28'd1 << 21;
  localparam logic [27:0] M_BAOUT   = 28'd1 << 22;
  localparam logic [27:0] M_COUT    = 28'd1 << 23;
  localparam logic [27:0] M_R15IN   = 28'd1 << 24;
  localparam logic [27:0] M_PORTIN  = 28'd1 << 25;
  localparam logic [27:0] M_PORTOUT = 28'd1 << 26;
  localparam logic [27:0] M_CONIN   = 28'd1 << 27;

  state_e      state_q, state_d;
  logic        stop_pend_q, stop_pend_d;
  cls_e        cls;
  logic [2:0]  last_step;
  logic [2:0]  step_idx;
  logic        in_exec;
  logic [27:0] strb;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^ir[26:0];

  always_comb begin
    cls = C_NOP;
    case (ir[31:27])
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd8, 5'd9, 5'd10, 5'd11: cls = C_ALU;
      5'd12, 5'd13, 5'd14:      cls = C_IMM;
      5'd17, 5'd18:             cls = C_UN;
      5'd15, 5'd16:             cls = C_MD;
      5'd1:                     cls = C_LDI;
      5'd0:                     cls = C_LD;
      5'd2:                     cls = C_ST;
      5'd19:                    cls = C_BR;
      5'd20:                    cls = C_JR;
      5'd21:                    cls = C_JAL;
      5'd22:                    cls = C_IN;
      5'd23:                    cls = C_OUT;
      5'd24:                    cls = C_MFHI;
      5'd25:                    cls = C_MFLO;
      5'd27:                    cls = C_HALT;
      default:                  cls = C_NOP;
    endcase
  end

  always_comb begin
    last_step = 3'd3;
    case (cls)
      C_ALU, C_IMM, C_LDI: last_step = 3'd5;
      C_UN, C_JAL:         last_step = 3'd4;
      C_MD, C_BR:          last_step = 3'd6;
      C_LD, C_ST:          last_step = 3'd7;
      default:             last_step = 3'd3;
    endcase
  end

  always_comb begin
    step_idx = 3'd0;
    run      = 1'b1;
    case (state_q)
      S_T0:    step_idx = 3'd0;
      S_T1:    step_idx = 3'd1;
      S_T2:    step_idx = 3'd2;
      S_T3:    step_idx = 3'd3;
      S_T4:    step_idx = 3'd4;
      S_T5:    step_idx = 3'd5;
      S_T6:    step_idx = 3'd6;
      S_T7:    step_idx = 3'd7;
      default: run = 1'b0;
    endcase
  end

  assign step    = step_idx;
  assign in_exec = run && (step_idx >= 3'd3);

  // A stop seen anywhere inside an instruction is held until its last step.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = run ? (stop_pend_q | stop) : 1'b0;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_T7;
      S_T7:    state_d = S_T0;
      default: state_d = S_HALT;
    endcase
    if (in_exec && step_idx >= last_step) begin
      stop_pend_d = 1'b0;
      if (cls == C_HALT || stop || stop_pend_q) state_d = S_HALT;
      else                                      state_d = S_T0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_RESET;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    strb = '0;
    case (state_q)
      S_T0: strb = M_PCOUT | M_MARIN | M_INCPC | M_RZIN;
      S_T1: strb = M_RZLOOUT | M_PCIN | M_READ | M_MDRIN;
      S_T2: strb = M_MDROUT | M_IRIN;
      S_T3: begin
        case (cls)
          C_ALU, C_IMM:       strb = M_GRB | M_ROUT | M_RYIN;
          C_UN:               strb = M_GRB | M_ROUT | M_RZIN;
          C_MD:               strb = M_GRA | M_ROUT | M_RYIN;
          C_LDI, C_LD, C_ST:  strb = M_GRB | M_BAOUT | M_RYIN;
          C_BR:               strb = M_GRA | M_ROUT | M_CONIN;
          C_JR:               strb = M_GRA | M_ROUT | M_PCIN;
          C_JAL:              strb = M_PCOUT | M_R15IN;
          C_IN:               strb = M_PORTOUT | M_GRA | M_RIN;
          C_OUT:              strb = M_GRA | M_ROUT | M_PORTIN;
          C_MFHI:             strb = M_HIOUT | M_GRA | M_RIN;
          C_MFLO:             strb = M_LOOUT | M_GRA | M_RIN;
          default:            strb = '0;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:                    strb = M_GRC | M_ROUT | M_RZIN;
          C_IMM, C_LDI, C_LD, C_ST: strb = M_COUT | M_RZIN;
          C_UN:                     strb = M_RZLOOUT | M_GRA | M_RIN;
          C_MD:                     strb = M_GRB | M_ROUT | M_RZIN;
          C_BR:                     strb = M_PCOUT | M_RYIN;
          C_JAL:                    strb = M_GRA | M_ROUT | M_PCIN;
          default:                  strb = '0;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: strb = M_RZLOOUT | M_GRA | M_RIN;
          C_MD:                strb = M_RZLOOUT | M_LOIN;
          C_LD, C_ST:          strb = M_RZLOOUT | M_MARIN;
          C_BR:                strb = M_COUT | M_RZIN;
          default:             strb = '0;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MD:    strb = M_RZHIOUT | M_HIIN;
          C_LD:    strb = M_READ | M_MDRIN;
          C_ST:    strb = M_GRA | M_ROUT | M_MDRIN;
          C_BR:    strb = M_RZLOOUT | (con_ff ? M_PCIN : '0);
          default: strb = '0;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    strb = M_MDROUT | M_GRA | M_RIN;
          C_ST:    strb = M_WRITE;
          default: strb = '0;
        endcase
      end
      default: strb = '0;
    endcase
  end

  assign {CONin, PORTout, PORTin, R15in, Cout, BAout, rout, rin, grc, grb, gra,
          LOout, HIout, LOin, HIin, RZHIout, RZLOout, RZin, RYin,
          IRin, Write, Read, MDRout, MDRin, MARin, PCin, IncPC, PCout} = strb;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit
// Each instruction is expanded into its expected per-cycle strobe list and compared cycle by cycle.
module tb_control_unit;

  typedef logic [27:0] mask_t;

  localparam mask_t PCOUT   = 28'd1 << 0;
  localparam mask_t INCPC   = 28'd1 << 1;
  localparam mask_t PCIN    = 28'd1 << 2;
  localparam mask_t MARIN   = 28'd1 << 3;
  localparam mask_t MDRIN   = 28'd1 << 4;
  localparam mask_t MDROUT  = 28'd1 << 5;
  localparam mask_t READ    = 28'd1 << 6;
  localparam mask_t WRITE   = 28'd1 << 7;
  localparam mask_t IRIN    = 28'd1 << 8;
  localparam mask_t RYIN    = 28'd1 << 9;
  localparam mask_t RZIN    = 28'd1 << 10;
  localparam mask_t RZLOOUT = 28'd1 << 11;
  localparam mask_t RZHIOUT = 28'd1 << 12;
  localparam mask_t HIIN    = 28'd1 << 13;
  localparam mask_t LOIN    = 28'd1 << 14;
  localparam mask_t HIOUT   = 28'd1 << 15;
  localparam mask_t LOOUT   = 28'd1 << 16;
  localparam mask_t GRA     = 28'd1 << 17;
  localparam mask_t GRB     = 28'd1 << 18;
  localparam mask_t GRC     = 28'd1 << 19;
  localparam mask_t RIN     = 28'd1 << 20;
  localparam mask_t ROUT    = 28'd1 << 21;
  localparam mask_t BAOUT   = 28'd1 << 22;
  localparam mask_t COUT    = 28'd1 << 23;
  localparam mask_t R15IN   = 28'd1 << 24;
  localparam mask_t PORTIN  = 28'd1 << 25;
  localparam mask_t PORTOUT = 28'd1 << 26;
  localparam mask_t CONIN   = 28'd1 << 27;

  logic        clock = 1'b0;
  logic        clear, con_ff, stop;
  logic [31:0] ir;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin;
  logic RYin, RZin, RZLOout, RZHIout, HIin, LOin, HIout, LOout;
  logic gra, grb, grc, rin, rout, BAout, Cout, R15in;
  logic PORTin, PORTout, CONin, run;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;
  mask_t seq [0:7];
  int    seq_len;
  bit    seq_halt;
  int    halt_cycles;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .RYin(RYin), .RZin(RZin), .RZLOout(RZLOout), .RZHIout(RZHIout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .BAout(BAout),
    .Cout(Cout), .R15in(R15in), .PORTin(PORTin), .PORTout(PORTout),
    .CONin(CONin), .run(run), .step(step)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] observed();
    return {run, step, CONin, PORTout, PORTin, R15in, Cout, BAout, rout, rin,
            grc, grb, gra, LOout, HIout, LOin, HIin, RZHIout, RZLOout, RZin, RYin,
            IRin, Write, Read, MDRout, MDRin, MARin, PCin, IncPC, PCout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic void add(input mask_t m);
    seq[seq_len] = m;
    seq_len++;
  endfunction

  // Expected microstep list of one instruction, fetch included.
  function automatic void build(input logic [4:0] op, input logic cf);
    seq_len  = 0;
    seq_halt = 1'b0;
    add(PCOUT | MARIN | INCPC | RZIN);
    add(RZLOOUT | PCIN | READ | MDRIN);
    add(MDROUT | IRIN);
    if (op >= 5'd3 && op <= 5'd11) begin
      add(GRB | ROUT | RYIN); add(GRC | ROUT | RZIN); add(RZLOOUT | GRA | RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      add(GRB | ROUT | RYIN); add(COUT | RZIN); add(RZLOOUT | GRA | RIN);
    end else if (op == 5'd17 || op == 5'd18) begin
      add(GRB | ROUT | RZIN); add(RZLOOUT | GRA | RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      add(GRA | ROUT | RYIN); add(GRB | ROUT | RZIN);
      add(RZLOOUT | LOIN); add(RZHIOUT | HIIN);
    end else if (op <= 5'd2) begin
      add(GRB | BAOUT | RYIN); add(COUT | RZIN);
      if (op == 5'd1) add(RZLOOUT | GRA | RIN);
      else begin
        add(RZLOOUT | MARIN);
        if (op == 5'd0) begin add(READ | MDRIN); add(MDROUT | GRA | RIN); end
        else begin add(GRA | ROUT | MDRIN); add(WRITE); end
      end
    end else begin
      case (op)
        5'd19: begin
          add(GRA | ROUT | CONIN); add(PCOUT | RYIN); add(COUT | RZIN);
          add(RZLOOUT | (cf ? PCIN : mask_t'(0)));
        end
        5'd20: add(GRA | ROUT | PCIN);
        5'd21: begin add(PCOUT | R15IN); add(GRA | ROUT | PCIN); end
        5'd22: add(PORTOUT | GRA | RIN);
        5'd23: add(GRA | ROUT | PORTIN);
        5'd24: add(HIOUT | GRA | RIN);
        5'd25: add(LOOUT | GRA | RIN);
        5'd27: begin add('0); seq_halt = 1'b1; end
        default: add('0);
      endcase
    end
  endfunction

  task automatic tick(input logic clr, input logic stp, input logic cf, input logic [31:0] irv);
    @(posedge clock);
    #2;
    clear  = clr;
    stop   = stp;
    con_ff = cf;
    ir     = irv;
    #1;
  endtask

  task automatic idle_zero(input string tag, input logic clr, input logic stp);
    tick(clr, stp, 1'b0, ir);
    check(tag, observed(), 32'h0);
  endtask

  // stop_at / abort_at >= instruction length mean "none".
  task automatic run_instr(input logic [4:0] op, input logic cf, input int stop_at, input int abort_at);
    logic [31:0] r;
    logic [31:0] irv;
    bit pend;
    r    = $urandom();
    irv  = {op, r[26:0]};
    pend = 1'b0;
    build(op, cf);
    for (int k = 0; k < seq_len; k++) begin
      tick(k == abort_at, k == stop_at, cf, irv);
      check($sformatf("op%0d_T%0d", op, k), observed(), {1'b1, 3'(k), seq[k]});
      if (k == abort_at) begin
        idle_zero($sformatf("abort_op%0d_T%0d", op, k), 1'b0, 1'b0);
        return;
      end
      if (k == stop_at) pend = 1'b1;
    end
    if (seq_halt || pend) begin
      for (int j = 0; j < halt_cycles; j++)
        idle_zero($sformatf("halt_op%0d_%0d", op, j), 1'b0, 1'($urandom_range(0, 1)));
      idle_zero("halt_clear", 1'b1, 1'b0);
      idle_zero("halt_reset", 1'b0, 1'b0);
    end
  endtask

  initial begin
    clear  = 1'b1;
    stop   = 1'b0;
    con_ff = 1'b0;
    ir     = 32'h0;
    halt_cycles = 20;

    idle_zero("reset0", 1'b1, 1'b0);
    idle_zero("reset1", 1'b1, 1'b0);
    idle_zero("reset_exit", 1'b0, 1'b0);

    run_instr(5'd3, 1'b0, 99, 99);
    run_instr(5'd3, 1'b0, 99, 99);
    run_instr(5'd0, 1'b0, 99, 99);
    run_instr(5'd2, 1'b0, 99, 99);
    run_instr(5'd19, 1'b1, 99, 99);
    run_instr(5'd19, 1'b0, 99, 99);
    run_instr(5'd27, 1'b0, 99, 99);
    run_instr(5'd0, 1'b0, 4, 99);
    run_instr(5'd2, 1'b0, 99, 6);
    run_instr(5'd3, 1'b0, 99, 99);
    run_instr(5'd21, 1'b0, 7, 99);

    halt_cycles = 3;
    for (int n = 0; n < 300; n++)
      run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), $urandom_range(0, 79));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
